vetris_input_reg_ctrl: RTL and testbench

- Owns the 32-bit input register that the Vetris CPU reads on `in_reg_data`.
- Arbitrates between two writers:
  - CPU write-backs (`final_isMoveOrWriteShape` with `input_reg_update`).
  - Player/gravity move commands: down, left, right.
- Move commands are posted one at a time into the low command field. Each is held until the CPU acknowledges it by clearing that field.
- Sits between the board button inputs, the gravity timer and the CPU top level.

---
 rtl/vetris_pkg.sv | 30 +++
 rtl/btn_sync_edge.sv | 27 ++
 rtl/vetris_input_reg_ctrl.sv | 147 ++++++++++++++
 tb/tb_vetris_input_reg_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vetris_pkg.sv
// Shared types for the Vetris input register: CMD field layout, command encodings, FSM states.
// Types only; no latency or backpressure of its own.
package vetris_pkg;

  localparam int CMD_LSB = 0;
  localparam int CMD_MSB = 2;
  localparam int CMD_W   = CMD_MSB - CMD_LSB + 1;

  // Encodings line up with the pending vector {right, left, down}
  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE  = 3'b000,
    CMD_DOWN  = 3'b001,
    CMD_LEFT  = 3'b010,
    CMD_RIGHT = 3'b100
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    POST,
    WAIT_ACK
  } fsm_state_t;

  function automatic cmd_t pick_cmd(input logic [CMD_W-1:0] pend);
    if (pend[0]) return CMD_DOWN;
    if (pend[1]) return CMD_LEFT;
    if (pend[2]) return CMD_RIGHT;
    return CMD_IDLE;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizes one asynchronous board button and emits a one-cycle pulse on its rising edge.
// Pulse appears SYNC_STAGES-1 cycles after the first sampling edge; no backpressure, held levels pulse once.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/vetris_input_reg_ctrl.sv
// Owns the CPU input register; posts button/gravity moves into CMD[2:0], one at a time, DOWN > LEFT > RIGHT.
// Button edge to CMD is 3 cycles when idle; CPU writes always win and a posted command holds until CMD is cleared.
module vetris_input_reg_ctrl
  import vetris_pkg::*;
#(
  parameter int GRAVITY_TICKS = 50_000_000,
  parameter int ACK_TIMEOUT   = 4096,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_wr_en,
  input  logic [31:0]      cpu_wr_data,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             game_en,
  output logic [31:0]      in_reg_data,
  output logic [CMD_W-1:0] pending,
  output logic             cmd_busy,
  output logic             ack_timeout_err
);

  localparam int GRAV_W = $clog2(GRAVITY_TICKS);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [GRAV_W-1:0] GRAV_LAST = GRAV_W'(GRAVITY_TICKS - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(ACK_TIMEOUT);

  logic [CMD_W-1:0]  btn_rise;
  logic [GRAV_W-1:0] grav_cnt;
  logic              grav_tick;
  logic [CMD_W-1:0]  new_req;
  logic [CMD_W-1:0]  cmd_q;
  logic [CMD_W-1:0]  cmd_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_inc;

  fsm_state_t        state_q;
  fsm_state_t        state_nxt;
  logic              do_post;
  cmd_t              post_cmd;
  logic [CMD_W-1:0]  clr_mask;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_down (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_down),
    .rise (btn_rise[0])
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_left (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_left),
    .rise (btn_rise[1])
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_right (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_right),
    .rise (btn_rise[2])
  );

  assign grav_tick  = game_en && (grav_cnt == GRAV_LAST);
  assign new_req    = game_en ? {btn_rise[2], btn_rise[1], btn_rise[0] | grav_tick} : '0;
  assign cmd_q      = in_reg_data[CMD_MSB:CMD_LSB];
  assign cmd_nxt    = cpu_wr_en ? cpu_wr_data[CMD_MSB:CMD_LSB] : cmd_q;
  assign to_cnt_inc = to_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grav_cnt <= '0;
    end else if (game_en) begin
      grav_cnt <= grav_tick ? '0 : grav_cnt + 1'b1;
    end
  end

  // IDLE looks at the incoming request too, so a fresh request is posted the cycle after it lands in pending
  always_comb begin
    state_nxt = state_q;
    do_post   = 1'b0;
    post_cmd  = CMD_IDLE;
    clr_mask  = '0;
    case (state_q)
      IDLE: begin
        if (((pending | new_req) != '0) && (cmd_nxt == '0)) begin
          state_nxt = POST;
        end
      end
      POST: begin
        if (cpu_wr_en || (pending == '0)) begin
          state_nxt = IDLE;
        end else begin
          do_post   = 1'b1;
          post_cmd  = pick_cmd(pending);
          clr_mask  = post_cmd;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cmd_q == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cmd_busy <= 1'b0;
      pending  <= '0;
    end else begin
      state_q  <= state_nxt;
      cmd_busy <= (state_nxt != IDLE);
      pending  <= (pending & ~clr_mask) | new_req;
    end
  end

  // Upper bits are only ever written by the CPU; a post touches CMD alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_reg_data <= '0;
    end else if (cpu_wr_en) begin
      in_reg_data <= cpu_wr_data;
    end else if (do_post) begin
      in_reg_data[CMD_MSB:CMD_LSB] <= post_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt          <= '0;
      ack_timeout_err <= 1'b0;
    end else if (state_q == POST) begin
      to_cnt <= '0;
    end else if ((state_q == WAIT_ACK) && (to_cnt != TO_LIMIT)) begin
      to_cnt <= to_cnt_inc;
      if (to_cnt_inc == TO_LIMIT) begin
        ack_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vetris_input_reg_ctrl.sv
// Directed bench: cycle-exact vector table for button/ack/CPU-override flows, plus hand sequences for timeout, async reset, gravity.
module tb_vetris_input_reg_ctrl;
  import vetris_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_wr_en = 1'b0;
  logic [31:0] cpu_wr_data = 32'h0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        game_en = 1'b1;

  logic [31:0] in_reg_data;
  logic [2:0]  pending;
  logic        cmd_busy;
  logic        ack_timeout_err;
  logic [31:0] g_reg;
  logic [2:0]  g_pend;
  logic        g_busy;
  logic        g_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vetris_input_reg_ctrl #(
    .GRAVITY_TICKS (1_000_000),
    .ACK_TIMEOUT   (16),
    .SYNC_STAGES   (2)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_wr_en       (cpu_wr_en),
    .cpu_wr_data     (cpu_wr_data),
    .btn_down        (btn_down),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .game_en         (game_en),
    .in_reg_data     (in_reg_data),
    .pending         (pending),
    .cmd_busy        (cmd_busy),
    .ack_timeout_err (ack_timeout_err)
  );

  vetris_input_reg_ctrl #(
    .GRAVITY_TICKS (8),
    .ACK_TIMEOUT   (16),
    .SYNC_STAGES   (2)
  ) u_grav (
    .clk             (clk),
    .rst             (rst),
    .cpu_wr_en       (cpu_wr_en),
    .cpu_wr_data     (cpu_wr_data),
    .btn_down        (btn_down),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .game_en         (game_en),
    .in_reg_data     (g_reg),
    .pending         (g_pend),
    .cmd_busy        (g_busy),
    .ack_timeout_err (g_err)
  );

  typedef struct {
    logic        dn;
    logic        lf;
    logic        rt;
    logic        wr;
    logic [31:0] wdat;
    logic [31:0] e_reg;
    logic [2:0]  e_pend;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic d, input logic l, input logic r, input logic w,
                     input logic [31:0] wd, input logic [31:0] er,
                     input logic [2:0] ep, input logic eb);
    vec_t v;
    v.dn = d; v.lf = l; v.rt = r; v.wr = w; v.wdat = wd;
    v.e_reg = er; v.e_pend = ep; v.e_busy = eb;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_post(input string nm, input logic [2:0] c);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (in_reg_data[2:0] == c) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    int posts[$];
    int exp_post[5];

    // --- reset state ---
    tick();
    chk("rst reg", in_reg_data, 32'h0);
    chk("rst pend", 32'(pending), 32'h0);
    chk("rst busy", 32'(cmd_busy), 32'h0);
    chk("rst err", 32'(ack_timeout_err), 32'h0);
    chk("rst g_reg", g_reg, 32'h0);
    chk("rst g_pend", 32'(g_pend), 32'h0);
    chk("rst g_busy", 32'(g_busy), 32'h0);
    chk("rst g_err", 32'(g_err), 32'h0);
    tick();
    rst = 1'b1;

    // --- cycle-exact vectors: d, l, r, wr, wdata | reg, pending, busy ---
    add(1'b1,1'b0,1'b0,1'b0, 32'h0,         32'h0,         3'b000, 1'b0);
    add(1'b1,1'b0,1'b0,1'b0, 32'h0,         32'h0,         3'b000, 1'b0);
    add(1'b1,1'b0,1'b0,1'b0, 32'h0,         32'h0,         3'b001, 1'b1);
    add(1'b1,1'b0,1'b0,1'b0, 32'h0,         32'h1,         3'b000, 1'b1);
    add(1'b1,1'b0,1'b0,1'b0, 32'h0,         32'h1,         3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h1,         3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h1,         3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b1, 32'h0000_1500, 32'h0000_1500, 3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0000_1500, 3'b000, 1'b0);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0000_1500, 3'b000, 1'b0);
    add(1'b0,1'b0,1'b0,1'b1, 32'hABCD_0000, 32'hABCD_0000, 3'b000, 1'b0);
    add(1'b0,1'b1,1'b1,1'b0, 32'h0,         32'hABCD_0000, 3'b000, 1'b0);
    add(1'b0,1'b1,1'b1,1'b0, 32'h0,         32'hABCD_0000, 3'b000, 1'b0);
    add(1'b0,1'b1,1'b1,1'b0, 32'h0,         32'hABCD_0000, 3'b110, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0002, 3'b100, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0002, 3'b100, 1'b1);
    add(1'b0,1'b0,1'b0,1'b1, 32'hABCD_0000, 32'hABCD_0000, 3'b100, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0000, 3'b100, 1'b0);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0000, 3'b100, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0004, 3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b1, 32'hABCD_0000, 32'hABCD_0000, 3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0000, 3'b000, 1'b0);
    add(1'b1,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0000, 3'b000, 1'b0);
    add(1'b1,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0000, 3'b000, 1'b0);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hABCD_0000, 3'b001, 1'b1);
    add(1'b0,1'b0,1'b0,1'b1, 32'h0000_2A00, 32'h0000_2A00, 3'b001, 1'b0);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0000_2A00, 3'b001, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0000_2A01, 3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b1, 32'h0000_2A00, 32'h0000_2A00, 3'b000, 1'b1);
    add(1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0000_2A00, 3'b000, 1'b0);

    foreach (vq[i]) begin
      btn_down    = vq[i].dn;
      btn_left    = vq[i].lf;
      btn_right   = vq[i].rt;
      cpu_wr_en   = vq[i].wr;
      cpu_wr_data = vq[i].wdat;
      tick();
      chk($sformatf("row%0d reg", i), in_reg_data, vq[i].e_reg);
      chk($sformatf("row%0d pend", i), 32'(pending), 32'(vq[i].e_pend));
      chk($sformatf("row%0d busy", i), 32'(cmd_busy), 32'(vq[i].e_busy));
      chk($sformatf("row%0d err", i), 32'(ack_timeout_err), 32'h0);
    end
    cpu_wr_en = 1'b0;
    cpu_wr_data = 32'h0;

    // --- ack timeout: post DOWN, never ack ---
    btn_down = 1'b1; tick(); tick(); btn_down = 1'b0;
    wait_post("to post", 3'b001);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("to err early", 32'(ack_timeout_err), 32'h0);
      if (i == 16) chk("to err set", 32'(ack_timeout_err), 32'h1);
    end
    repeat (5) tick();
    chk("to err sticky", 32'(ack_timeout_err), 32'h1);
    chk("to busy", 32'(cmd_busy), 32'h1);
    chk("to reg held", in_reg_data, 32'h0000_2A01);
    cpu_wr_en = 1'b1; cpu_wr_data = 32'h0;
    tick();
    cpu_wr_en = 1'b0;
    chk("to ack reg", in_reg_data, 32'h0);
    tick();
    chk("to ack idle", 32'(cmd_busy), 32'h0);
    chk("to err after ack", 32'(ack_timeout_err), 32'h1);

    // --- async reset mid WAIT_ACK with pending 110 ---
    btn_down = 1'b1; tick(); tick(); btn_down = 1'b0;
    wait_post("rst post", 3'b001);
    btn_left = 1'b1; btn_right = 1'b1;
    tick(); tick();
    btn_left = 1'b0; btn_right = 1'b0;
    tick(); tick();
    chk("pre-rst pend", 32'(pending), 32'h6);
    chk("pre-rst busy", 32'(cmd_busy), 32'h1);
    chk("pre-rst reg", in_reg_data, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst reg", in_reg_data, 32'h0);
    chk("arst pend", 32'(pending), 32'h0);
    chk("arst busy", 32'(cmd_busy), 32'h0);
    chk("arst err", 32'(ack_timeout_err), 32'h0);
    tick(); tick();
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (in_reg_data != 32'h0 || pending != 3'b000 || cmd_busy) bad++;
    end
    chk("post-rst quiet cycles", 32'(bad), 32'h0);

    // --- gravity on the 8-tick instance ---
    tick();
    rst = 1'b0;
    game_en = 1'b1;
    tick();
    rst = 1'b1;
    exp_post = '{9, 17, 25, 33, 61};
    for (int e = 1; e <= 64; e++) begin
      game_en = (e <= 36 || e >= 57);
      tick();
      cpu_wr_en = 1'b0;
      if (g_reg[2:0] != 3'b000) begin
        posts.push_back(e);
        cpu_wr_en = 1'b1;
        cpu_wr_data = 32'h0;
      end
    end
    cpu_wr_en = 1'b0;
    chk("grav post count", 32'(posts.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < posts.size()) chk($sformatf("grav post%0d edge", k), 32'(posts[k]), 32'(exp_post[k]));
      else chk($sformatf("grav post%0d missing", k), 32'h0, 32'(exp_post[k]));
    end
    chk("grav err", 32'(g_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
